// File: rtl/dca_matrix_load_row_streamer.sv
// Streams the rows of one strided row-load instruction from memory to the matrix load path.
// Credits (in-flight reads + buffered rows <= BUF_DEPTH) mean responses never need back-pressure.
module dca_matrix_load_row_streamer #(
    parameter int BW_TENSOR_ROW = 128,
    parameter int BW_ADDR       = 32,
    parameter int BW_NUM_ROW    = 5,
    parameter int BUF_DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rstnn,
    input  logic                     clear,
    input  logic                     enable,
    output logic                     busy,
    output logic                     inst_wready,
    input  logic                     inst_wvalid,
    input  logic [BW_ADDR-1:0]       inst_base_addr,
    input  logic [BW_ADDR-1:0]       inst_stride,
    input  logic [BW_NUM_ROW-1:0]    inst_num_row,
    output logic                     mem_rreq_valid,
    input  logic                     mem_rreq_ready,
    output logic [BW_ADDR-1:0]       mem_rreq_addr,
    input  logic                     mem_rrsp_valid,
    input  logic [BW_TENSOR_ROW-1:0] mem_rrsp_data,
    input  logic                     load_tensor_row_wready,
    output logic                     load_tensor_row_wvalid,
    output logic                     load_tensor_row_wlast,
    output logic [BW_TENSOR_ROW-1:0] load_tensor_row_wdata
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]         DEPTH_C = CW'(BUF_DEPTH);
    localparam logic [BW_NUM_ROW-1:0] ROW_ONE = BW_NUM_ROW'(1);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    state_t                   state_q, state_d;
    logic [BW_ADDR-1:0]       addr_q, stride_q;
    logic [BW_NUM_ROW-1:0]    num_q, req_cnt_q, out_cnt_q;
    logic [CW-1:0]            inflight_q, buf_cnt_q, discard_q;
    logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [BW_TENSOR_ROW-1:0] row_buf_q [BUF_DEPTH];

    logic active, discarding, credit_ok;
    logic inst_fire, rreq_fire, beat_fire, rsp_push, rsp_drop;

    always_comb begin
        active     = (state_q == ST_ACTIVE);
        discarding = (discard_q != '0);
        credit_ok  = ({1'b0, inflight_q} + {1'b0, buf_cnt_q}) < {1'b0, DEPTH_C};
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (inst_fire && inst_num_row != '0) state_d = ST_ACTIVE;
                ST_ACTIVE: if (beat_fire && load_tensor_row_wlast) state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        inst_wready            = ~active & ~discarding;
        busy                   = active | discarding;
        mem_rreq_valid         = enable & active & (req_cnt_q < num_q) & credit_ok;
        mem_rreq_addr          = addr_q;
        load_tensor_row_wvalid = enable & (buf_cnt_q != '0);
        load_tensor_row_wlast  = active & (out_cnt_q == num_q - ROW_ONE);
        load_tensor_row_wdata  = row_buf_q[rd_ptr_q];
    end

    always_comb begin
        inst_fire = inst_wvalid & inst_wready & enable & ~clear;
        rreq_fire = mem_rreq_valid & mem_rreq_ready;
        beat_fire = load_tensor_row_wvalid & load_tensor_row_wready;
        rsp_drop  = mem_rrsp_valid & discarding;
        rsp_push  = mem_rrsp_valid & ~discarding & ~clear;
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            addr_q     <= '0;
            stride_q   <= '0;
            num_q      <= '0;
            req_cnt_q  <= '0;
            out_cnt_q  <= '0;
            inflight_q <= '0;
            buf_cnt_q  <= '0;
            discard_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else if (clear) begin
            req_cnt_q  <= '0;
            out_cnt_q  <= '0;
            inflight_q <= '0;
            buf_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            // Everything still owed by memory, including a read accepted this cycle, is dropped later.
            discard_q  <= discard_q + inflight_q + CW'(rreq_fire) - CW'(mem_rrsp_valid);
        end else begin
            if (inst_fire) begin
                addr_q    <= inst_base_addr;
                stride_q  <= inst_stride;
                num_q     <= inst_num_row;
                req_cnt_q <= '0;
                out_cnt_q <= '0;
            end
            if (rreq_fire) begin
                addr_q    <= addr_q + stride_q;
                req_cnt_q <= req_cnt_q + ROW_ONE;
            end
            if (rsp_drop)  discard_q <= discard_q - CW'(1);
            if (rsp_push)  wr_ptr_q  <= wr_ptr_q + PW'(1);
            if (beat_fire) begin
                rd_ptr_q  <= rd_ptr_q + PW'(1);
                out_cnt_q <= out_cnt_q + ROW_ONE;
            end
            inflight_q <= inflight_q + CW'(rreq_fire) - CW'(rsp_push);
            buf_cnt_q  <= buf_cnt_q + CW'(rsp_push) - CW'(beat_fire);
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn)        row_buf_q <= '{default: '0};
        else if (rsp_push) row_buf_q[wr_ptr_q] <= mem_rrsp_data;
    end

    rsp_no_overflow: assert property (@(posedge clk) disable iff (!rstnn)
        !(rsp_push && buf_cnt_q == DEPTH_C));

endmodule

// File: tb/tb_dca_matrix_load_row_streamer.sv
// Bench for dca_matrix_load_row_streamer: memory model with configurable latency/readiness,
// randomized consumer, and expectations computed as base+i*stride with address-derived data.
module tb_dca_matrix_load_row_streamer;

    localparam int BW_T  = 128;
    localparam int BW_A  = 32;
    localparam int BW_N  = 5;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rstnn, clear, enable, busy, inst_wready, inst_wvalid;
    logic [BW_A-1:0] inst_base_addr, inst_stride, mem_rreq_addr;
    logic [BW_N-1:0] inst_num_row;
    logic mem_rreq_valid, mem_rreq_ready, mem_rrsp_valid;
    logic [BW_T-1:0] mem_rrsp_data, load_tensor_row_wdata;
    logic load_tensor_row_wready, load_tensor_row_wvalid, load_tensor_row_wlast;

    typedef struct { logic [BW_T-1:0] data; int unsigned due; } rsp_t;
    rsp_t            pend[$];
    logic [BW_A-1:0] obs_addr[$];
    logic [BW_T:0]   obs_beat[$];
    int unsigned     req_cyc[$], beat_cyc[$];

    int unsigned cyc = 0, inst_cyc = 0, req_fire_total = 0;
    int unsigned mem_lat = 0, req_limit = 32'hFFFF_FFFF;
    bit mem_rdy_rand = 0, cons_hold = 0, cons_rand = 0, chk_discard = 0, en_rand = 0;
    bit saw_busy = 0, saw_nready = 0;
    int max_out = 0;
    int unsigned en_viol = 0, disc_viol = 0, disc_rsp = 0;
    int unsigned pass_cnt = 0, total_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dca_matrix_load_row_streamer #(
        .BW_TENSOR_ROW(BW_T), .BW_ADDR(BW_A), .BW_NUM_ROW(BW_N), .BUF_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rstnn(rstnn), .clear(clear), .enable(enable), .busy(busy),
        .inst_wready(inst_wready), .inst_wvalid(inst_wvalid), .inst_base_addr(inst_base_addr),
        .inst_stride(inst_stride), .inst_num_row(inst_num_row),
        .mem_rreq_valid(mem_rreq_valid), .mem_rreq_ready(mem_rreq_ready), .mem_rreq_addr(mem_rreq_addr),
        .mem_rrsp_valid(mem_rrsp_valid), .mem_rrsp_data(mem_rrsp_data),
        .load_tensor_row_wready(load_tensor_row_wready), .load_tensor_row_wvalid(load_tensor_row_wvalid),
        .load_tensor_row_wlast(load_tensor_row_wlast), .load_tensor_row_wdata(load_tensor_row_wdata)
    );

    function automatic logic [BW_T-1:0] mem_data(input logic [BW_A-1:0] a);
        logic [BW_A-1:0] h;
        h = a * 32'd2654435761;
        return {a ^ 32'hDEADBEEF, ~a, h, a + 32'h1234_5678};
    endfunction

    // Memory responder and consumer, driven just after each rising edge.
    initial begin
        mem_rrsp_valid = 1'b0; mem_rrsp_data = '0; mem_rreq_ready = 1'b0; load_tensor_row_wready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rstnn) begin
                pend.delete();
                mem_rrsp_valid = 1'b0;
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                mem_rrsp_valid = 1'b1;
                mem_rrsp_data  = pend[0].data;
                void'(pend.pop_front());
            end else begin
                mem_rrsp_valid = 1'b0;
                mem_rrsp_data  = '0;
            end
            mem_rreq_ready = (req_fire_total < req_limit) && (!mem_rdy_rand || $urandom_range(0, 1) == 1);
            load_tensor_row_wready = !cons_hold && (!cons_rand || $urandom_range(0, 2) != 0);
        end
    end

    // Observes handshakes that will fire on the next rising edge.
    always @(negedge clk) begin
        if (rstnn) begin
            if (inst_wvalid && inst_wready && enable && !clear) inst_cyc = cyc + 1;
            if (mem_rreq_valid && mem_rreq_ready) begin
                obs_addr.push_back(mem_rreq_addr);
                req_cyc.push_back(cyc + 1);
                req_fire_total++;
                pend.push_back('{mem_data(mem_rreq_addr), cyc + 1 + mem_lat});
            end
            if (load_tensor_row_wvalid && load_tensor_row_wready) begin
                obs_beat.push_back({load_tensor_row_wlast, load_tensor_row_wdata});
                beat_cyc.push_back(cyc + 1);
            end
            if (int'(obs_addr.size()) - int'(obs_beat.size()) > max_out)
                max_out = int'(obs_addr.size()) - int'(obs_beat.size());
            if (!enable && (mem_rreq_valid || load_tensor_row_wvalid)) en_viol++;
            if (busy) saw_busy = 1;
            if (!inst_wready) saw_nready = 1;
            if (chk_discard && mem_rrsp_valid) disc_rsp++;
            if (chk_discard && (pend.size() > 0 || mem_rrsp_valid) && (!busy || inst_wready)) disc_viol++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clear_obs();
        obs_addr.delete(); obs_beat.delete(); req_cyc.delete(); beat_cyc.delete();
        max_out = 0; saw_busy = 0; saw_nready = 0; en_viol = 0; disc_viol = 0; disc_rsp = 0;
    endtask

    task automatic send_inst(input logic [BW_A-1:0] b, input logic [BW_A-1:0] s, input logic [BW_N-1:0] n);
        bit done = 0;
        step();
        inst_base_addr = b; inst_stride = s; inst_num_row = n; inst_wvalid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk); #2;
            if (inst_wready && enable && !clear) done = 1;
        end
        step();
        inst_wvalid = 1'b0;
        chk("inst_accept", done, 1);
    endtask

    task automatic expect_stream(input string tag, input logic [BW_A-1:0] b, input logic [BW_A-1:0] s, input int n);
        bit done = 0;
        logic [BW_A-1:0] ea;
        for (int i = 0; i < 3000 && !done; i++) begin
            step();
            if (en_rand) enable = ($urandom_range(0, 3) != 0);
            @(negedge clk); #2;
            if (int'(obs_beat.size()) >= n && !busy) done = 1;
        end
        enable = 1'b1;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_nreq"}, obs_addr.size(), n);
        chk({tag, "_nbeat"}, obs_beat.size(), n);
        for (int i = 0; i < n; i++) begin
            ea = b + s * 32'(i);
            if (i < int'(obs_addr.size())) chk($sformatf("%s_addr%0d", tag, i), obs_addr[i], ea);
            if (i < int'(obs_beat.size()))
                chk($sformatf("%s_beat%0d", tag, i), obs_beat[i], {(i == n - 1) ? 1'b1 : 1'b0, mem_data(ea)});
        end
        chk({tag, "_credit"}, (max_out <= DEPTH), 1);
    endtask

    initial begin
        logic [BW_A-1:0] b, s;
        int n;
        bit done;
        rstnn = 1'b0; clear = 1'b0; enable = 1'b1; inst_wvalid = 1'b0;
        inst_base_addr = '0; inst_stride = '0; inst_num_row = '0;
        repeat (3) step();
        rstnn = 1'b1;
        @(negedge clk); #2;
        chk("rst_busy", busy, 0);
        chk("rst_inst_wready", inst_wready, 1);
        chk("rst_rreq_valid", mem_rreq_valid, 0);
        chk("rst_rreq_addr", mem_rreq_addr, 0);
        chk("rst_wvalid", load_tensor_row_wvalid, 0);
        chk("rst_wlast", load_tensor_row_wlast, 0);
        chk("rst_wdata", load_tensor_row_wdata, 0);

        // T1: zero-wait memory and consumer
        clear_obs();
        send_inst(32'h1000, 32'h10, 4);
        expect_stream("t1", 32'h1000, 32'h10, 4);
        if (req_cyc.size() == 4) chk("t1_req0_latency", req_cyc[0], inst_cyc + 1);
        if (beat_cyc.size() == 4)
            for (int i = 0; i < 4; i++) chk($sformatf("t1_beat%0d_cycle", i), beat_cyc[i], inst_cyc + 3 + i);

        // T2: consumer stalled, credits limit requests
        clear_obs();
        b = $urandom; s = $urandom_range(1, 64) * 4;
        cons_hold = 1;
        send_inst(b, s, 8);
        repeat (20) step();
        chk("t2_stall_nreq", obs_addr.size(), DEPTH);
        chk("t2_stall_nbeat", obs_beat.size(), 0);
        cons_hold = 0;
        expect_stream("t2", b, s, 8);

        // T3: address wrap
        clear_obs();
        send_inst(32'hFFFF_FFF0, 32'h10, 3);
        expect_stream("t3", 32'hFFFF_FFF0, 32'h10, 3);
        if (obs_addr.size() == 3) begin
            chk("t3_wrap0", obs_addr[0], 32'hFFFF_FFF0);
            chk("t3_wrap1", obs_addr[1], 32'h0000_0000);
            chk("t3_wrap2", obs_addr[2], 32'h0000_0010);
        end

        // T4: zero-row instruction
        clear_obs();
        send_inst($urandom, $urandom, 0);
        repeat (10) step();
        chk("t4_nreq", obs_addr.size(), 0);
        chk("t4_nbeat", obs_beat.size(), 0);
        chk("t4_saw_busy", saw_busy, 0);
        chk("t4_saw_not_ready", saw_nready, 0);

        // T5: clear with reads in flight
        clear_obs();
        mem_lat = 2; req_limit = req_fire_total + 3; cons_hold = 1;
        b = $urandom; s = $urandom_range(1, 255);
        send_inst(b, s, 6);
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk); #2;
            if (obs_addr.size() >= 3) done = 1;
        end
        chk("t5_three_reqs", done, 1);
        step(); clear = 1'b1;
        step(); clear = 1'b0; chk_discard = 1; cons_hold = 0;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk); #2;
            if (pend.size() == 0 && !mem_rrsp_valid) done = 1;
        end
        chk("t5_drained", done, 1);
        chk("t5_busy_after_drain", busy, 0);
        chk("t5_ready_after_drain", inst_wready, 1);
        chk("t5_dropped", disc_rsp, 2);
        chk("t5_busy_while_owed", disc_viol, 0);
        chk("t5_nbeat", obs_beat.size(), 0);
        chk("t5_nreq", obs_addr.size(), 3);
        chk_discard = 0; mem_lat = 0; req_limit = 32'hFFFF_FFFF;
        clear_obs();
        b = $urandom; s = $urandom;
        send_inst(b, s, 5);
        expect_stream("t5b", b, s, 5);

        // T6: async reset mid-stream
        clear_obs();
        mem_lat = 1;
        send_inst($urandom, $urandom_range(1, 1024), 8);
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk); #2;
            if (obs_beat.size() >= 2) done = 1;
        end
        chk("t6_started", done, 1);
        @(posedge clk); #3;
        rstnn = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_inst_wready", inst_wready, 1);
        chk("t6_rst_rreq_valid", mem_rreq_valid, 0);
        chk("t6_rst_wvalid", load_tensor_row_wvalid, 0);
        chk("t6_rst_wlast", load_tensor_row_wlast, 0);
        repeat (2) step();
        rstnn = 1'b1;

        // enable low blocks instruction acceptance, then random enable pulses mid-stream
        clear_obs();
        b = $urandom; s = $urandom_range(0, 255) << 4;
        enable = 1'b0;
        step();
        inst_base_addr = b; inst_stride = s; inst_num_row = 10; inst_wvalid = 1'b1;
        repeat (5) step();
        @(negedge clk); #2;
        chk("t6_en0_busy", busy, 0);
        chk("t6_en0_nreq", obs_addr.size(), 0);
        inst_wvalid = 1'b0;
        enable = 1'b1;
        send_inst(b, s, 10);
        en_rand = 1; mem_rdy_rand = 1; cons_rand = 1;
        expect_stream("t6", b, s, 10);
        en_rand = 0;
        chk("t6_fire_while_disabled", en_viol, 0);

        // randomized instructions
        for (int k = 0; k < 6; k++) begin
            clear_obs();
            mem_lat = $urandom_range(0, 3);
            mem_rdy_rand = $urandom_range(0, 1);
            cons_rand = $urandom_range(0, 1);
            b = $urandom; s = $urandom;
            n = $urandom_range(1, 31);
            send_inst(b, s, BW_N'(n));
            expect_stream($sformatf("rnd%0d", k), b, s, n);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
